// File: rtl/rob_retire_pkg.sv
// Shared sizes, tag types and ROB entry layout for the in-order retirement buffer.
package rob_retire_pkg;
   localparam int N          = 2;
   localparam int ROB_SZ     = 16;
   localparam int PR_COUNT   = 64;
   localparam int ARCH_COUNT = 32;

   localparam int PHYS_W = $clog2(PR_COUNT);
   localparam int ARCH_W = $clog2(ARCH_COUNT);
   localparam int IDX_W  = $clog2(ROB_SZ);
   localparam int CNT_W  = $clog2(ROB_SZ + 1);
   localparam int SLOT_W = $clog2(N + 1);

   typedef logic [PHYS_W-1:0] phys_tag_t;
   typedef logic [ARCH_W-1:0] arch_tag_t;
   typedef logic [IDX_W-1:0]  rob_idx_t;
   typedef logic [SLOT_W-1:0] slot_cnt_t;

   typedef struct packed {
      logic      valid;
      logic      complete;
      logic      mispredict;
      logic      has_dest;
      arch_tag_t arch_rd;
      phys_tag_t new_tag;
      phys_tag_t old_tag;
   } rob_entry_t;

   function automatic slot_cnt_t lane_popcount(input logic [N-1:0] v);
      slot_cnt_t c;
      c = '0;
      for (int i = 0; i < N; i++) c = c + slot_cnt_t'(v[i]);
      return c;
   endfunction
endpackage

// File: rtl/rob_retire_if.sv
// Dispatch, completion and retirement signals between the core pipeline and the ROB.
interface rob_retire_if;
   import rob_retire_pkg::*;

   logic [N-1:0]               disp_valid;
   logic [N-1:0]               disp_has_dest;
   arch_tag_t [N-1:0]          disp_arch_rd;
   phys_tag_t [N-1:0]          disp_new_tag;
   phys_tag_t [N-1:0]          disp_old_tag;
   slot_cnt_t                  rob_free_slots;
   rob_idx_t  [N-1:0]          disp_rob_idx;

   logic [N-1:0]               cdb_valid;
   rob_idx_t  [N-1:0]          cdb_rob_idx;
   logic [N-1:0]               cdb_mispredict;

   logic [N-1:0]               RetireEN;
   phys_tag_t [N-1:0]          RetireReg;
   logic                       BPRecoverEN;
   phys_tag_t [ARCH_COUNT-1:0] archi_maptable;
   slot_cnt_t                  retire_count;

   modport master (
      output disp_valid, disp_has_dest, disp_arch_rd, disp_new_tag, disp_old_tag,
      output cdb_valid, cdb_rob_idx, cdb_mispredict,
      input  rob_free_slots, disp_rob_idx,
      input  RetireEN, RetireReg, BPRecoverEN, archi_maptable, retire_count
   );

   modport slave (
      input  disp_valid, disp_has_dest, disp_arch_rd, disp_new_tag, disp_old_tag,
      input  cdb_valid, cdb_rob_idx, cdb_mispredict,
      output rob_free_slots, disp_rob_idx,
      output RetireEN, RetireReg, BPRecoverEN, archi_maptable, retire_count
   );
endinterface

// File: rtl/rob_retire_sel.sv
// Prefix retire-select over the N oldest entries: an unbroken run of complete
// entries retires, and a mispredicted branch closes its group.
module rob_retire_sel
   import rob_retire_pkg::*;
(
   input  logic [N-1:0] head_valid,
   input  logic [N-1:0] head_complete,
   input  logic [N-1:0] head_mispredict,
   output logic [N-1:0] retire_lane,
   output slot_cnt_t    retire_num,
   output logic         retire_flush
);
   logic run;

   always_comb begin
      // NOTE: blocking '=' is intended: run carries the prefix from lane to lane within one evaluation.
      run          = 1'b1;
      retire_lane  = '0;
      retire_flush = 1'b0;
      for (int k = 0; k < N; k++) begin
         run            = run & head_valid[k] & head_complete[k];
         retire_lane[k] = run;
         if (run && head_mispredict[k]) retire_flush = 1'b1;
         run            = run & ~head_mispredict[k];
      end
      retire_num = lane_popcount(retire_lane);
   end
endmodule

// File: rtl/rob_retire.sv
// ROB-lite: in-order dispatch/complete/retire, returns old tags to the freelist
// and keeps the precise architectural map; a retired mispredict flushes everything.
module rob_retire
   import rob_retire_pkg::*;
(
   input logic         clock,
   input logic         reset,
   rob_retire_if.slave bus
);
   rob_entry_t                 rob_q [ROB_SZ];
   rob_idx_t                   head_q;
   rob_idx_t                   tail_q;
   logic [CNT_W-1:0]           count_q;
   logic                       recover_q;
   logic [N-1:0]               retire_en_q;
   phys_tag_t [N-1:0]          retire_reg_q;
   slot_cnt_t                  retire_count_q;
   phys_tag_t [ARCH_COUNT-1:0] map_q;

   logic [CNT_W-1:0]  free_entries;
   slot_cnt_t         free_slots;
   slot_cnt_t         disp_num;
   slot_cnt_t         alloc_num;
   logic              alloc_go;
   rob_idx_t [N-1:0]  disp_idx;
   rob_idx_t          disp_offs;

   rob_idx_t   [N-1:0] head_idx;
   rob_entry_t [N-1:0] head_ents;
   logic [N-1:0]       head_valid;
   logic [N-1:0]       head_complete;
   logic [N-1:0]       head_mispredict;
   logic [N-1:0]       retire_lane;
   logic [N-1:0]       commit_lane;
   slot_cnt_t          retire_num;
   logic               retire_flush;

   // Free space comes only from registered state, never from this cycle's retirement.
   always_comb begin
      free_entries = CNT_W'(ROB_SZ) - count_q;
      if (recover_q)                          free_slots = '0;
      else if (free_entries >= CNT_W'(N))     free_slots = SLOT_W'(N);
      else                                    free_slots = SLOT_W'(free_entries);
   end

   always_comb begin
      // NOTE: every variable written here gets a value before the loop, so no latch is inferred.
      disp_offs = '0;
      disp_idx  = '0;
      for (int i = 0; i < N; i++) begin
         disp_idx[i] = tail_q + disp_offs;
         disp_offs   = disp_offs + rob_idx_t'(bus.disp_valid[i]);
      end
   end

   assign disp_num  = lane_popcount(bus.disp_valid);
   assign alloc_go  = (disp_num != '0) && (disp_num <= free_slots) && !retire_flush;
   assign alloc_num = alloc_go ? disp_num : '0;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         head_idx[k]        = head_q + rob_idx_t'(k);
         head_ents[k]       = rob_q[head_idx[k]];
         head_valid[k]      = head_ents[k].valid;
         head_complete[k]   = head_ents[k].complete;
         head_mispredict[k] = head_ents[k].mispredict;
      end
   end

   rob_retire_sel u_sel (
      .head_valid      (head_valid),
      .head_complete   (head_complete),
      .head_mispredict (head_mispredict),
      .retire_lane     (retire_lane),
      .retire_num      (retire_num),
      .retire_flush    (retire_flush)
   );

   always_comb begin
      for (int k = 0; k < N; k++)
         commit_lane[k] = retire_lane[k] & head_ents[k].has_dest & (head_ents[k].arch_rd != '0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: non-blocking '<=' for all sequential state so every register samples pre-edge values.
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         recover_q      <= 1'b0;
         retire_en_q    <= '0;
         retire_reg_q   <= '0;
         retire_count_q <= '0;
         for (int r = 0; r < ARCH_COUNT; r++) map_q[r] <= phys_tag_t'(r);
      end else begin
         recover_q      <= retire_flush;
         retire_count_q <= retire_num;
         // Ascending lane order: the last write to a shared rd (highest lane) wins.
         for (int k = 0; k < N; k++) begin
            retire_en_q[k] <= commit_lane[k] && !retire_flush;
            if (retire_lane[k]) retire_reg_q[k] <= head_ents[k].old_tag;
            if (commit_lane[k]) map_q[head_ents[k].arch_rd] <= head_ents[k].new_tag;
         end
         if (retire_flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            head_q  <= head_q + rob_idx_t'(retire_num);
            tail_q  <= tail_q + rob_idx_t'(alloc_num);
            count_q <= count_q + CNT_W'(alloc_num) - CNT_W'(retire_num);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: only the flag bits are reset; payload is don't-care until the entry is allocated.
         for (int e = 0; e < ROB_SZ; e++) begin
            rob_q[e].valid      <= 1'b0;
            rob_q[e].complete   <= 1'b0;
            rob_q[e].mispredict <= 1'b0;
         end
      end else begin
         if (!recover_q) begin
            for (int i = 0; i < N; i++) begin
               if (bus.cdb_valid[i]) begin
                  rob_q[bus.cdb_rob_idx[i]].complete   <= 1'b1;
                  rob_q[bus.cdb_rob_idx[i]].mispredict <= bus.cdb_mispredict[i];
               end
            end
         end
         for (int k = 0; k < N; k++)
            if (retire_lane[k]) rob_q[head_idx[k]].valid <= 1'b0;
         if (retire_flush) begin
            for (int e = 0; e < ROB_SZ; e++) rob_q[e].valid <= 1'b0;
         end else if (alloc_go) begin
            for (int i = 0; i < N; i++) begin
               if (bus.disp_valid[i])
                  rob_q[disp_idx[i]] <= '{valid:      1'b1,
                                          complete:   1'b0,
                                          mispredict: 1'b0,
                                          has_dest:   bus.disp_has_dest[i],
                                          arch_rd:    bus.disp_arch_rd[i],
                                          new_tag:    bus.disp_new_tag[i],
                                          old_tag:    bus.disp_old_tag[i]};
            end
         end
      end
   end

   assign bus.rob_free_slots = free_slots;
   assign bus.disp_rob_idx   = disp_idx;
   assign bus.RetireEN       = retire_en_q;
   assign bus.RetireReg      = retire_reg_q;
   assign bus.BPRecoverEN    = recover_q;
   assign bus.archi_maptable = map_q;
   assign bus.retire_count   = retire_count_q;
endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire with a queue-based program-order model checked every cycle.
`timescale 1ns/1ps
module tb_rob_retire;
   import rob_retire_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   rob_retire_if bus ();
   rob_retire dut (.clock(clock), .reset(reset), .bus(bus));

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Program-order model: a queue of in-flight instructions, oldest first.
   typedef struct {
      int idx; bit hd; int rd; int nt; int ot; bit cp; bit mp;
   } m_ent_t;

   m_ent_t       mq[$];
   int           m_tail;
   int           m_map [ARCH_COUNT];
   bit [N-1:0]   m_en;
   int           m_reg [N];
   bit           m_rec;
   int           m_cnt;
   bit           m_ok = 1'b0;

   function automatic int m_free();
      int room;
      room = ROB_SZ - mq.size();
      if (m_rec) return 0;
      return (room < N) ? room : N;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_tail = 0;
      m_en   = '0;
      m_rec  = 1'b0;
      m_cnt  = 0;
      foreach (m_map[r]) m_map[r] = r;
      m_ok   = 1'b1;
   endtask

   task automatic model_step();
      int     free;
      int     ndisp;
      int     nret;
      bit     flush;
      m_ent_t e;
      free  = m_free();
      nret  = 0;
      flush = 1'b0;
      m_en  = '0;
      while (nret < N && mq.size() > 0 && !flush) begin
         if (!mq[0].cp) break;
         e = mq.pop_front();
         if (e.hd && e.rd != 0) begin
            m_map[e.rd] = e.nt;
            m_en[nret]  = 1'b1;
            m_reg[nret] = e.ot;
         end
         if (e.mp) flush = 1'b1;
         nret++;
      end
      m_cnt = nret;
      if (!m_rec) begin
         for (int i = 0; i < N; i++) begin
            if (bus.cdb_valid[i]) begin
               for (int j = 0; j < mq.size(); j++) begin
                  if (mq[j].idx == int'(bus.cdb_rob_idx[i])) begin
                     e = mq[j]; e.cp = 1'b1; e.mp = bus.cdb_mispredict[i]; mq[j] = e;
                  end
               end
            end
         end
      end
      ndisp = $countones(bus.disp_valid);
      if (flush) begin
         mq.delete();
         m_tail = 0;
         m_en   = '0;
      end else if (ndisp <= free) begin
         for (int i = 0; i < N; i++) begin
            if (bus.disp_valid[i]) begin
               e.idx = m_tail; e.hd = bus.disp_has_dest[i]; e.rd = int'(bus.disp_arch_rd[i]);
               e.nt = int'(bus.disp_new_tag[i]); e.ot = int'(bus.disp_old_tag[i]);
               e.cp = 1'b0; e.mp = 1'b0;
               mq.push_back(e);
               m_tail = (m_tail + 1) % ROB_SZ;
            end
         end
      end
      m_rec = flush;
   endtask

   // Advance the model on each edge, then compare registered outputs just after it.
   always @(posedge clock) begin
      if (reset) model_reset();
      else if (m_ok) model_step();
      #1;
      if (m_ok) begin
         check("rob_free_slots", bus.rob_free_slots, m_free());
         check("BPRecoverEN", bus.BPRecoverEN, m_rec);
         check("retire_count", bus.retire_count, m_cnt);
         check("RetireEN", bus.RetireEN, m_en);
         for (int k = 0; k < N; k++)
            if (m_en[k]) check($sformatf("RetireReg[%0d]", k), bus.RetireReg[k], m_reg[k]);
         for (int r = 0; r < ARCH_COUNT; r++)
            check($sformatf("archi_maptable[%0d]", r), bus.archi_maptable[r], m_map[r]);
      end
   end

   task automatic idle_inputs();
      bus.disp_valid     = '0;
      bus.disp_has_dest  = '0;
      bus.disp_arch_rd   = '0;
      bus.disp_new_tag   = '0;
      bus.disp_old_tag   = '0;
      bus.cdb_valid      = '0;
      bus.cdb_rob_idx    = '0;
      bus.cdb_mispredict = '0;
   endtask

   task automatic next_cycle();
      @(negedge clock);
      idle_inputs();
   endtask

   task automatic disp(input int lane, input bit hd, input int rd, input int nt, input int ot);
      bus.disp_valid[lane]    = 1'b1;
      bus.disp_has_dest[lane] = hd;
      bus.disp_arch_rd[lane]  = arch_tag_t'(rd);
      bus.disp_new_tag[lane]  = phys_tag_t'(nt);
      bus.disp_old_tag[lane]  = phys_tag_t'(ot);
   endtask

   task automatic cdb(input int lane, input int idx, input bit mp);
      bus.cdb_valid[lane]      = 1'b1;
      bus.cdb_rob_idx[lane]    = rob_idx_t'(idx);
      bus.cdb_mispredict[lane] = mp;
   endtask

   task automatic chk_disp_idx();
      int offs;
      #1;
      offs = 0;
      for (int i = 0; i < N; i++) begin
         if (bus.disp_valid[i]) begin
            check($sformatf("disp_rob_idx[%0d]", i), bus.disp_rob_idx[i], (m_tail + offs) % ROB_SZ);
            offs++;
         end
      end
   endtask

   int pairs [8][2] = '{'{3, 1}, '{2, 4}, '{5, 6}, '{7, 8},
                        '{9, 10}, '{11, 12}, '{13, 14}, '{15, -1}};

   initial begin
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      check("rst_map5", bus.archi_maptable[5], 5);
      check("rst_free", bus.rob_free_slots, 2);
      check("rst_retire_en", bus.RetireEN, 0);
      check("rst_bprecover", bus.BPRecoverEN, 0);

      // Single instruction rd=5
      next_cycle(); disp(0, 1'b1, 5, 32, 5); chk_disp_idx();
      next_cycle(); cdb(0, 0, 1'b0);
      next_cycle();
      next_cycle();
      check("t1_retire_en", bus.RetireEN, 2'b01);
      check("t1_retire_reg0", bus.RetireReg[0], 5);
      check("t1_map5", bus.archi_maptable[5], 32);
      check("t1_retire_count", bus.retire_count, 1);

      // Two lanes writing the same rd in one group
      next_cycle(); disp(0, 1'b1, 7, 33, 7); disp(1, 1'b1, 7, 34, 33); chk_disp_idx();
      check("t2_idx0", bus.disp_rob_idx[0], 1);
      check("t2_idx1", bus.disp_rob_idx[1], 2);
      next_cycle(); cdb(0, 1, 1'b0); cdb(1, 2, 1'b0);
      next_cycle();
      next_cycle();
      check("t2_retire_en", bus.RetireEN, 2'b11);
      check("t2_retire_reg0", bus.RetireReg[0], 7);
      check("t2_retire_reg1", bus.RetireReg[1], 33);
      check("t2_map7", bus.archi_maptable[7], 34);
      check("t2_retire_count", bus.retire_count, 2);

      // Fill, out-of-order completion, in-order drain with tail wrap
      next_cycle(); reset = 1'b1;
      next_cycle(); reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         disp(0, 1'b1, 1 + 2*c, 40 + 2*c, 1 + 2*c);
         disp(1, 1'b1, 2 + 2*c, 41 + 2*c, 2 + 2*c);
         chk_disp_idx();
         next_cycle();
      end
      check("full_free", bus.rob_free_slots, 0);
      disp(0, 1'b1, 30, 63, 30);
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         cdb(0, pairs[c][0], 1'b0);
         if (pairs[c][1] >= 0) cdb(1, pairs[c][1], 1'b0);
      end
      next_cycle();
      next_cycle();
      check("ooo_no_retire", bus.retire_count, 0);
      check("ooo_still_full", bus.rob_free_slots, 0);
      cdb(0, 0, 1'b0);
      next_cycle();
      next_cycle();
      check("ooo_retire_count", bus.retire_count, 2);
      check("ooo_retire_reg0", bus.RetireReg[0], 1);
      check("ooo_retire_reg1", bus.RetireReg[1], 2);
      check("ooo_free", bus.rob_free_slots, 2);
      disp(0, 1'b1, 20, 56, 20); disp(1, 1'b1, 21, 57, 21); chk_disp_idx();
      check("wrap_idx0", bus.disp_rob_idx[0], 0);
      check("wrap_idx1", bus.disp_rob_idx[1], 1);
      next_cycle();
      check("ooo2_retire_reg0", bus.RetireReg[0], 3);
      check("ooo2_retire_reg1", bus.RetireReg[1], 4);
      check("ooo2_map3", bus.archi_maptable[3], 42);
      cdb(0, 0, 1'b0); cdb(1, 1, 1'b0);
      repeat (10) next_cycle();
      check("drain_map16", bus.archi_maptable[16], 55);
      check("drain_map20", bus.archi_maptable[20], 56);
      check("drain_map21", bus.archi_maptable[21], 57);

      // Mispredicted branch at idx 2 flushes idx 3
      next_cycle(); reset = 1'b1;
      next_cycle(); reset = 1'b0;
      disp(0, 1'b1, 3, 60, 3); disp(1, 1'b1, 4, 61, 4);
      next_cycle(); disp(0, 1'b0, 0, 0, 0); disp(1, 1'b1, 5, 62, 5); cdb(0, 0, 1'b0); cdb(1, 1, 1'b0);
      next_cycle(); cdb(0, 2, 1'b1); cdb(1, 3, 1'b0);
      next_cycle();
      check("bp_group_en", bus.RetireEN, 2'b11);
      disp(0, 1'b1, 9, 63, 9);
      next_cycle();
      check("bp_pulse", bus.BPRecoverEN, 1);
      check("bp_retire_en", bus.RetireEN, 0);
      check("bp_retire_count", bus.retire_count, 1);
      check("bp_free", bus.rob_free_slots, 0);
      check("bp_map3", bus.archi_maptable[3], 60);
      check("bp_map4", bus.archi_maptable[4], 61);
      check("bp_map5", bus.archi_maptable[5], 5);
      cdb(0, 3, 1'b0); disp(0, 1'b1, 9, 63, 9);
      next_cycle();
      check("bp_pulse_end", bus.BPRecoverEN, 0);
      check("bp_free_back", bus.rob_free_slots, 2);
      disp(0, 1'b1, 9, 63, 9); chk_disp_idx();
      check("bp_restart_idx", bus.disp_rob_idx[0], 0);
      next_cycle(); cdb(0, 0, 1'b0);
      next_cycle();
      next_cycle();
      check("bp_after_map9", bus.archi_maptable[9], 63);

      // Reset with 10 entries in flight
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         disp(0, 1'b1, 10 + 2*c, 30 + 2*c, 10 + 2*c);
         disp(1, 1'b1, 11 + 2*c, 31 + 2*c, 11 + 2*c);
      end
      next_cycle(); cdb(0, 2, 1'b0); cdb(1, 3, 1'b0);
      next_cycle(); reset = 1'b1; cdb(0, 1, 1'b0);
      next_cycle(); reset = 1'b0;
      check("rst2_free", bus.rob_free_slots, 2);
      check("rst2_map9", bus.archi_maptable[9], 9);
      check("rst2_map10", bus.archi_maptable[10], 10);
      check("rst2_retire_en", bus.RetireEN, 0);
      check("rst2_retire_count", bus.retire_count, 0);
      disp(0, 1'b1, 12, 50, 12); chk_disp_idx();
      check("rst2_idx0", bus.disp_rob_idx[0], 0);
      repeat (4) next_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
In-order retirement buffer (ROB-lite) that owns the return side of the physical-register freelist.
- Accepts up to N renamed instructions per cycle from Dispatch and records their completion from the CDB.
- Retires up to N instructions per cycle in program order and drives RetireEN/RetireReg (old tags) to the freelist.
- Maintains the precise architectural map table; on a retired mispredicted branch, flushes itself and pulses BPRecoverEN so the freelist can rebuild from archi_maptable.

Parameters:
- N, 2, dispatch/complete/retire width.
- ROB_SZ, 16, entries; power of 2, at least N.
- PR_COUNT, 64, physical registers.
- ARCH_COUNT, 32, architectural registers.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- disp_valid  in  N  per-lane dispatch request.
- disp_has_dest  in  N  lane writes a register.
- disp_arch_rd  in  N x 5  architectural destination.
- disp_new_tag  in  N x PHYS_TAG  tag allocated from the freelist.
- disp_old_tag  in  N x PHYS_TAG  previous mapping of rd.
- rob_free_slots  out  clog2(N+1)  min(N, free entries); 0 while BPRecoverEN=1.
- disp_rob_idx  out  N x ROB_IDX  index assigned to the k-th valid lane.
- cdb_valid  in  N  completion strobe.
- cdb_rob_idx  in  N x ROB_IDX  completing entry.
- cdb_mispredict  in  N  completing entry is a mispredicted branch.
- RetireEN  out  N  freelist return enable.
- RetireReg  out  N x PHYS_TAG  old tag returned.
- BPRecoverEN  out  1  one-cycle recovery pulse.
- archi_maptable  out  ARCH_COUNT x PHYS_TAG  precise map.
- retire_count  out  clog2(N+1)  instructions retired this cycle (registered).

Behaviour:
- Reset:
  - head=tail=0, count=0, all valid/complete bits cleared.
  - RetireEN=0, BPRecoverEN=0, retire_count=0.
  - archi_maptable[r]=r.
  - Reset asserted mid-operation discards all state on that edge.
- Dispatch:
  - Valid lanes are compacted in lane order into tail, tail+1, ... (mod ROB_SZ).
  - All-or-nothing: if popcount(disp_valid) > rob_free_slots, nothing is allocated.
  - A new entry clears complete/mispredict.
  - disp_rob_idx is combinational from tail.
- Completion:
  - cdb_valid[i] sets complete (and mispredict) of entry cdb_rob_idx[i] on the next edge.
  - Completion of the entry being allocated in the same cycle is not allowed.
- Retire select (combinational):
  - Lane k retires iff entries head..head+k are all valid and complete, and none of head..head+k-1 is mispredicted.
  - A mispredicted branch retires itself but is the last of its group.
- Commit edge (edge after select), for each retired entry with has_dest and rd≠0:
  - archi_maptable[rd] <= new_tag; higher lane wins on same-rd conflict.
  - RetireReg[k] <= old_tag, RetireEN[k] <= has_dest && rd≠0.
  - head += retired, count updated as count + allocated - retired in a single update.
- Mispredict commit, same edge:
  - All entries flushed: head=tail=count=0.
  - Dispatch that cycle dropped.
  - BPRecoverEN<=1 for exactly one cycle with RetireEN forced to 0.
  - archi_maptable already includes the group's updates when BPRecoverEN is high.
- Cycle with BPRecoverEN=1: rob_free_slots=0 and cdb inputs are ignored. Upstream issues no stale CDB broadcasts afterwards.
- Boundaries:
  - Full: rob_free_slots=0.
  - Pointers wrap mod ROB_SZ.
  - Simultaneous dispatch and retire when full is allowed only after retirement frees slots; the free count is sampled from the registered count.

Decomposition:
- Shared package: PHYS_TAG, ARCH_TAG, ROB_IDX typedefs; rob_entry_t struct {valid, complete, mispredict, has_dest, arch_rd, new_tag, old_tag}; ROB_SZ constant.
- Sub-module: rob_retire_sel, the combinational prefix retire-select over N head entries.

Test Plan:
- Reset -> archi_maptable[5]=5, rob_free_slots=2, RetireEN=0, BPRecoverEN=0.
- Dispatch rd=5 new=32 old=5, complete, retire -> RetireEN[0]=1, RetireReg[0]=5, archi_maptable[5]=32, retire_count=1.
- Two lanes both rd=7 (new 33/34, old 7/33), both complete -> RetireReg={7,33}, archi_maptable[7]=34.
- Fill 16 entries, complete out of order (idx 3 before 0) -> rob_free_slots=0 when full; nothing retires until idx 0 completes; then 2 per cycle in order; wrap-around indices correct.
- Branch at idx 2 mispredicted, idx 3 complete -> idx 0-2 retire, idx 3 flushed, BPRecoverEN=1 for 1 cycle, RetireEN=0 that cycle, count=0, rob_free_slots=0 that cycle.
- Reset asserted with 10 entries in flight -> next cycle count=0, map restored to identity, no RetireEN.
